// File: rtl/dmem_seq.sv
// Address sequencer for a data memory: one write burst followed by one read burst.
// The pointers step by a common stride and wrap silently; clr and rst abort with no done pulse.
module dmem_seq #(
    parameter int AddrDMEM = 8,
    parameter int LenWidth = AddrDMEM + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clr,
    input  logic [AddrDMEM-1:0] w_base,
    input  logic [AddrDMEM-1:0] r_base,
    input  logic [AddrDMEM-1:0] stride,
    input  logic [LenWidth-1:0] len,
    input  logic [1:0]          in_sel,
    input  logic [1:0]          out_sel,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic [AddrDMEM-1:0] w_addr,
    output logic [AddrDMEM-1:0] r_addr,
    output logic                we,
    output logic [3:0]          cfgdat,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AddrDMEM-1:0] w_ptr_q, w_ptr_d;
    logic [AddrDMEM-1:0] r_ptr_q, r_ptr_d;
    logic [AddrDMEM-1:0] stride_q, stride_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic [1:0]          in_sel_q, in_sel_d;
    logic [1:0]          out_sel_q, out_sel_d;
    logic [LenWidth-1:0] cnt_inc;

    // The counter is one bit wider than an address, so len = 2^AddrDMEM still fits.
    assign cnt_inc = cnt_q + LenWidth'(1);

    always_comb begin
        state_d   = state_q;
        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_ptr_d   = w_base;
                        r_ptr_d   = r_base;
                        stride_d  = stride;
                        len_d     = len;
                        in_sel_d  = in_sel;
                        out_sel_d = out_sel;
                        cnt_d     = '0;
                        state_d   = (len == '0) ? S_DONE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (in_valid) begin
                        w_ptr_d = w_ptr_q + stride_q;
                        if (cnt_inc == len_q) begin
                            cnt_d   = '0;
                            state_d = S_READ;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        r_ptr_d = r_ptr_q + stride_q;
                        if (cnt_inc == len_q) begin
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            in_sel_q  <= '0;
            out_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            stride_q  <= stride_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
        end
    end

    // Addresses are gated to zero outside their phase so that an idle block drives all zeros.
    assign we        = (state_q == S_WRITE) && in_valid;
    assign w_addr    = (state_q == S_WRITE) ? w_ptr_q : '0;
    assign r_addr    = (state_q == S_READ) ? r_ptr_q : '0;
    assign out_valid = (state_q == S_READ);
    assign cfgdat    = ((state_q == S_WRITE) || (state_q == S_READ)) ? {out_sel_q, in_sel_q} : 4'b0000;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
